// File: rtl/tile_board_scheduler.sv
// rtl/tile_board_scheduler.sv - tile board store with render-priority game-port scheduling
//
// Purpose: holds the ROWS x COLS board of 4-bit cell codes, translates the
// current pixel into a tile ROM index/address two cycles later, and serves the
// game-logic read/write ports only in store slots the renderer does not need.
//
// Ports:
//   pixel_clk, rst_n            clock, synchronous active-low reset
//   h_coord, v_coord            current pixel coordinates
//   wr_req/wr_row/wr_col/wr_code, wr_ack           cell write port
//   rd_req/rd_row/rd_col, rd_ack, rd_code          cell read port
//   tile_sel, tile_addr, tile_valid                render output (2-cycle latency)
//   init_busy                   board clear in progress
module tile_board_scheduler #(
  parameter int COLS = 25,
  parameter int ROWS = 18,
  parameter int TILE = 32
) (
  input  logic        pixel_clk,
  input  logic        rst_n,
  input  logic [10:0] h_coord,
  input  logic [9:0]  v_coord,
  input  logic        wr_req,
  input  logic [4:0]  wr_row,
  input  logic [4:0]  wr_col,
  input  logic [3:0]  wr_code,
  output logic        wr_ack,
  input  logic        rd_req,
  input  logic [4:0]  rd_row,
  input  logic [4:0]  rd_col,
  output logic        rd_ack,
  output logic [3:0]  rd_code,
  output logic [3:0]  tile_sel,
  output logic [9:0]  tile_addr,
  output logic        tile_valid,
  output logic        init_busy
);

  localparam int CELLS = ROWS * COLS;
  localparam int IW    = $clog2(CELLS);
  localparam int SH    = $clog2(TILE);
  localparam logic [IW-1:0] LAST_IDX = IW'(CELLS - 1);
  localparam logic [3:0] CODE_HIDDEN = 4'd9;

  typedef enum logic [1:0] {INIT, IDLE, WR, RD} state_t;
  state_t state, state_nxt;

  logic [3:0]    board [CELLS];
  logic [IW-1:0] init_idx;
  logic          in_area;
  logic          game_wr, game_rd;
  logic [4:0]    g_row, g_col;
  logic          g_ok;
  logic [IW-1:0] g_idx, render_idx;
  logic [IW-1:0] mem_addr;
  logic          mem_we;
  logic [3:0]    mem_wdata, mem_rdata, mem_q;
  logic          s1_valid;
  logic [9:0]    s1_addr;

  function automatic logic [3:0] tile_of(input logic [3:0] code);
    if (code == 4'd0)                        return 4'd12;
    else if (code >= 4'd1 && code <= 4'd8)   return code + 4'd1;
    else if (code == 4'd10)                  return 4'd1;
    else if (code == 4'd11)                  return 4'd10;
    else if (code == 4'd12)                  return 4'd11;
    else                                     return 4'd0;
  endfunction

  // Any pixel off the board frees the store slot for the game ports.
  assign in_area = (int'(h_coord) < COLS * TILE) && (int'(v_coord) < ROWS * TILE);

  assign game_wr = (state == IDLE) && !in_area && wr_req;
  assign game_rd = (state == IDLE) && !in_area && !wr_req && rd_req;

  assign g_row = game_wr ? wr_row : rd_row;
  assign g_col = game_wr ? wr_col : rd_col;
  assign g_ok  = (int'(g_row) < ROWS) && (int'(g_col) < COLS);
  assign g_idx = IW'(int'(g_row) * COLS + int'(g_col));

  always_comb begin
    render_idx = '0;
    if (in_area)
      render_idx = IW'((int'(v_coord) >> SH) * COLS + (int'(h_coord) >> SH));
  end

  // Single store port: init clear, else a granted game access, else render read.
  always_comb begin
    mem_addr  = render_idx;
    mem_we    = 1'b0;
    mem_wdata = wr_code;
    if (state == INIT) begin
      mem_addr  = init_idx;
      mem_we    = 1'b1;
      mem_wdata = CODE_HIDDEN;
    end else if (game_wr || game_rd) begin
      mem_addr = g_ok ? g_idx : '0;
      mem_we   = game_wr && g_ok;
    end
  end

  assign mem_rdata = board[mem_addr];

  always_ff @(posedge pixel_clk) begin
    if (mem_we)
      board[mem_addr] <= mem_wdata;
    mem_q <= mem_rdata;
  end

  always_ff @(posedge pixel_clk) begin
    if (!rst_n) begin
      state      <= INIT;
      init_idx   <= '0;
      rd_code    <= 4'd0;
      s1_valid   <= 1'b0;
      s1_addr    <= 10'd0;
      tile_valid <= 1'b0;
      tile_sel   <= 4'd0;
      tile_addr  <= 10'd0;
    end else begin
      state <= state_nxt;
      if (state == INIT)
        init_idx <= (init_idx == LAST_IDX) ? '0 : init_idx + 1'b1;
      if (game_rd)
        rd_code <= g_ok ? mem_rdata : CODE_HIDDEN;
      // Stage 1: store read in flight; stage 2: code to tile index.
      s1_valid   <= in_area && (state != INIT);
      s1_addr    <= {v_coord[4:0], h_coord[4:0]};
      tile_valid <= s1_valid;
      tile_sel   <= s1_valid ? tile_of(mem_q) : 4'd0;
      tile_addr  <= s1_addr;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_ack    = 1'b0;
    rd_ack    = 1'b0;
    init_busy = 1'b0;
    case (state)
      INIT: begin
        init_busy = 1'b1;
        if (init_idx == LAST_IDX) state_nxt = IDLE;
      end
      IDLE: begin
        if (game_wr)      state_nxt = WR;
        else if (game_rd) state_nxt = RD;
      end
      WR: begin
        wr_ack    = 1'b1;
        state_nxt = IDLE;
      end
      RD: begin
        rd_ack    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = INIT;
    endcase
  end

endmodule

// File: tb/tb_tile_board_scheduler.sv
// tb/tb_tile_board_scheduler.sv - scoreboard bench for tile_board_scheduler
module tb_tile_board_scheduler;

  localparam int COLS = 25;
  localparam int ROWS = 18;
  localparam int TILE = 32;

  logic        pixel_clk = 1'b0;
  logic        rst_n;
  logic [10:0] h_coord;
  logic [9:0]  v_coord;
  logic        wr_req;
  logic [4:0]  wr_row, wr_col;
  logic [3:0]  wr_code;
  logic        wr_ack;
  logic        rd_req;
  logic [4:0]  rd_row, rd_col;
  logic        rd_ack;
  logic [3:0]  rd_code;
  logic [3:0]  tile_sel;
  logic [9:0]  tile_addr;
  logic        tile_valid;
  logic        init_busy;

  tile_board_scheduler #(.COLS(COLS), .ROWS(ROWS), .TILE(TILE)) dut (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .h_coord   (h_coord),
    .v_coord   (v_coord),
    .wr_req    (wr_req),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_code   (wr_code),
    .wr_ack    (wr_ack),
    .rd_req    (rd_req),
    .rd_row    (rd_row),
    .rd_col    (rd_col),
    .rd_ack    (rd_ack),
    .rd_code   (rd_code),
    .tile_sel  (tile_sel),
    .tile_addr (tile_addr),
    .tile_valid(tile_valid),
    .init_busy (init_busy)
  );

  always #14 pixel_clk = ~pixel_clk;

  typedef struct {
    int due;
    int valid;
    int sel;
    int addr;
  } rexp_t;

  rexp_t rq[$];
  int    rd_q[$];
  int    model[ROWS][COLS];
  int    n_checks = 0;
  int    n_errors = 0;
  int    cyc = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_tile(input int code);
    case (code)
      0:  return 12;
      1, 2, 3, 4, 5, 6, 7, 8: return code + 1;
      10: return 1;
      11: return 10;
      12: return 11;
      default: return 0;
    endcase
  endfunction

  always @(posedge pixel_clk) cyc = cyc + 1;

  always @(negedge pixel_clk) begin
    while (rq.size() > 0 && rq[0].due == cyc) begin
      rexp_t e;
      e = rq.pop_front();
      check("tile_valid", int'(tile_valid), e.valid);
      check("tile_sel", int'(tile_sel), e.sel);
      check("tile_addr", int'(tile_addr), e.addr);
    end
  end

  task automatic clear_model();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        model[r][c] = 9;
  endtask

  task automatic pix(input int h, input int v);
    rexp_t e;
    h_coord = 11'(h);
    v_coord = 10'(v);
    e.due   = cyc + 2;
    e.valid = (h < COLS * TILE && v < ROWS * TILE) ? 1 : 0;
    e.sel   = e.valid ? exp_tile(model[v / TILE][h / TILE]) : 0;
    e.addr  = ((v & 31) << 5) | (h & 31);
    rq.push_back(e);
    @(posedge pixel_clk); #1;
  endtask

  task automatic blank();
    h_coord = 11'd900;
    v_coord = 10'd0;
    repeat (3) @(posedge pixel_clk);
    #1;
  endtask

  task automatic do_write(input int r, input int c, input int code);
    int got;
    wr_row = 5'(r); wr_col = 5'(c); wr_code = 4'(code); wr_req = 1'b1;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pixel_clk);
      if (wr_ack) begin got = 1; break; end
    end
    check("wr_ack_seen", got, 1);
    wr_req = 1'b0;
    if (got == 1 && r < ROWS && c < COLS) model[r][c] = code;
    @(negedge pixel_clk);
    check("wr_ack_single", int'(wr_ack), 0);
    @(posedge pixel_clk); #1;
  endtask

  task automatic do_read(input int r, input int c);
    int got;
    rd_q.push_back((r < ROWS && c < COLS) ? model[r][c] : 9);
    rd_row = 5'(r); rd_col = 5'(c); rd_req = 1'b1;
    got = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge pixel_clk);
      if (rd_ack) begin got = 1; break; end
    end
    if (got == 1) check("rd_code", int'(rd_code), rd_q.pop_front());
    else begin
      check("rd_ack_timeout", got, 1);
      void'(rd_q.pop_front());
    end
    rd_req = 1'b0;
    @(negedge pixel_clk);
    check("rd_ack_single", int'(rd_ack), 0);
    check("rd_code_hold", int'(rd_code), got == 1 ? int'(rd_code) : 0);
    @(posedge pixel_clk); #1;
  endtask

  task automatic count_init(output int busy_cycles, output int acks);
    busy_cycles = 0;
    acks = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge pixel_clk);
      if (wr_ack || rd_ack) acks++;
      if (init_busy) busy_cycles++;
      else break;
    end
  endtask

  initial begin
    int busy, acks, got;
    rst_n = 1'b0;
    h_coord = 11'd900; v_coord = 10'd0;
    wr_req = 1'b0; wr_row = '0; wr_col = '0; wr_code = '0;
    rd_req = 1'b0; rd_row = '0; rd_col = '0;
    clear_model();

    repeat (2) @(posedge pixel_clk);
    @(negedge pixel_clk);
    check("rst_wr_ack", int'(wr_ack), 0);
    check("rst_rd_ack", int'(rd_ack), 0);
    check("rst_rd_code", int'(rd_code), 0);
    check("rst_tile_sel", int'(tile_sel), 0);
    check("rst_tile_addr", int'(tile_addr), 0);
    check("rst_tile_valid", int'(tile_valid), 0);
    check("rst_init_busy", int'(init_busy), 1);

    @(posedge pixel_clk); #1;
    rst_n = 1'b1;
    count_init(busy, acks);
    check("init_cycles", busy, 450);
    @(posedge pixel_clk); #1;

    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        do_read(r, c);

    pix(0, 0); pix(31, 31); pix(400, 300); pix(799, 575); pix(799, 0); pix(0, 575);
    blank();

    do_write(2, 5, 3);
    pix(170, 70);
    blank();

    do_write(0, 0, 10);
    do_write(0, 1, 11);
    do_write(0, 2, 12);
    do_write(0, 3, 0);
    do_write(0, 4, 8);
    do_write(0, 6, 13);
    do_write(17, 24, 1);
    pix(5, 5); pix(40, 7); pix(70, 31); pix(100, 0); pix(140, 20); pix(200, 10);
    pix(799, 575); pix(160, 64);
    pix(10, 580); pix(810, 10); pix(800, 0); pix(0, 576);
    blank();

    h_coord = 11'd100; v_coord = 10'd100;
    wr_row = 5'd3; wr_col = 5'd7; wr_code = 4'd8;
    rd_row = 5'd3; rd_col = 5'd7;
    wr_req = 1'b1; rd_req = 1'b1;
    rd_q.push_back(8);
    acks = 0;
    repeat (20) begin
      @(negedge pixel_clk);
      if (wr_ack || rd_ack) acks++;
    end
    check("no_ack_in_board", acks, 0);
    h_coord = 11'd800;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge pixel_clk);
      if (rd_ack) break;
      if (wr_ack) begin got = 1; break; end
    end
    check("write_first", got, 1);
    wr_req = 1'b0;
    model[3][7] = 8;
    got = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge pixel_clk);
      if (rd_ack) begin got = 1; break; end
    end
    check("read_after_write_ack", got, 1);
    check("read_after_write", int'(rd_code), rd_q.pop_front());
    rd_req = 1'b0;
    @(posedge pixel_clk); #1;
    blank();

    do_write(20, 3, 5);
    do_write(0, 25, 5);
    do_read(1, 0);
    do_read(2, 3);
    do_read(2, 30);
    do_read(18, 0);
    do_read(3, 7);

    rst_n = 1'b0;
    @(posedge pixel_clk); #1;
    rst_n = 1'b1;
    clear_model();
    repeat (200) @(posedge pixel_clk);
    #1;
    wr_row = 5'd1; wr_col = 5'd1; wr_code = 4'd4; wr_req = 1'b1;
    rd_row = 5'd1; rd_col = 5'd1; rd_req = 1'b1;
    rst_n = 1'b0;
    @(posedge pixel_clk); #1;
    rst_n = 1'b1;
    count_init(busy, acks);
    wr_req = 1'b0; rd_req = 1'b0;
    check("reinit_cycles", busy, 450);
    check("reinit_no_acks", acks, 0);
    @(posedge pixel_clk); #1;
    do_read(1, 1);
    do_read(0, 0);
    pix(5, 5); pix(170, 70);
    blank();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tile_board_scheduler.md
TILE_BOARD_SCHEDULER -- requirements
Module: tile_board_scheduler

Interface
REQ-001 SHALL have parameters: COLS, default 25, number of board columns; ROWS, default 18, number of board rows; TILE, default 32, tile edge in pixels (power of two).
REQ-002 SHALL have ports: pixel_clk  in  1  pixel clock, 36 MHz.
REQ-003 SHALL have: rst_n  in  1  reset; synchronous, active-low.
REQ-004 SHALL have: h_coord  in  11, v_coord  in  10  current pixel coordinates.
REQ-005 SHALL have: wr_req  in  1, wr_row  in  5, wr_col  in  5, wr_code  in  4, wr_ack  out  1  game-logic cell write port.
REQ-006 SHALL have: rd_req  in  1, rd_row  in  5, rd_col  in  5, rd_ack  out  1, rd_code  out  4  game-logic cell read port.
REQ-007 SHALL have: tile_sel  out  4  tile ROM index; tile_addr  out  10  address within 32x32 tile; tile_valid  out  1  pixel lies on board.
REQ-008 SHALL have: init_busy  out  1  board clear in progress.

Function
REQ-009 SHALL hold a single-port board store of ROWS*COLS 4-bit cells, index = row*COLS+col, with one access per cycle.
REQ-010 Cell codes SHALL be: 0 revealed empty; 1-8 revealed number; 9 hidden; 10 flag; 11 mine; 12 exploded mine; 13-15 treated as hidden.
REQ-011 tile_sel mapping SHALL be: hidden->0, flag->1, number n->n+1 (2..9), mine->10, exploded->11, empty->12.
REQ-012 Board area SHALL be h_coord < COLS*TILE and v_coord < ROWS*TILE (800x576 by default).
REQ-013 Render pipeline SHALL be 2 cycles: tile_sel, tile_addr, tile_valid correspond to the coordinates presented 2 cycles earlier.
REQ-014 tile_addr SHALL equal {v_coord[4:0], h_coord[4:0]} of that pixel; col = h_coord/TILE, row = v_coord/TILE.
REQ-015 tile_valid SHALL be 1 only for delayed in-area pixels while init_busy=0; otherwise tile_valid=0 and tile_sel=0.
REQ-016 FSM states SHALL be INIT, IDLE, WR, RD.
REQ-017 INIT SHALL write code 9 to every cell, one cell per cycle in index order, ignoring the render and game ports, then go to IDLE; init_busy=1 exactly while in INIT.
REQ-018 Render reads SHALL have absolute priority: the store slot is granted to game ports only when the current pixel is outside the board area.
REQ-019 In IDLE with a granted slot, SHALL go to WR if wr_req=1, else to RD if rd_req=1; write wins on simultaneous requests.
REQ-020 WR SHALL perform the write and pulse wr_ack for exactly 1 cycle, then return to IDLE.
REQ-021 RD SHALL read the cell, drive rd_code and pulse rd_ack for exactly 1 cycle on the cycle after the read; rd_code SHALL hold until the next read.
REQ-022 A requester SHALL hold req and its fields stable until ack; req may be deasserted in the ack cycle; a req still high after ack starts a new transaction.
REQ-023 Out-of-range row (>=ROWS) or col (>=COLS) SHALL be acknowledged normally; the write is dropped and the read returns rd_code=9.
REQ-024 A write to the cell currently being rendered SHALL be visible on the next render of that cell; no bypass is required.
REQ-025 Maximum game-port latency from req to ack SHALL be bounded by the next non-board pixel plus 2 cycles.

Reset
REQ-026 On rst_n=0: FSM->INIT, init index->0, wr_ack=0, rd_ack=0, rd_code=0, tile_sel=0, tile_addr=0, tile_valid=0, init_busy=1 on the first cycle after reset.
REQ-027 Reset asserted mid-INIT, mid-WR or mid-RD SHALL abort the operation and restart INIT from index 0; pending acks are not issued.

Verification
REQ-028 Reset then release -> init_busy=1 for exactly 450 cycles; all cells read back 9; tile_sel=0 with tile_valid=1 in the board area afterwards.
REQ-029 Write code 3 to row 2, col 5 during horizontal blanking -> wr_ack is a single pulse; pixel (h=170, v=70) yields tile_sel=4 and tile_addr={5'd6, 5'd10} two cycles later.
REQ-030 wr_req and rd_req raised together while h_coord=100, v_coord=100 -> no ack until h_coord>=800; the write completes first, then the read returns the written value.
REQ-031 Write row=20 col=3 -> wr_ack is issued and board unchanged; read row=2 col=30 -> rd_code=9.
REQ-032 Reset pulsed at INIT index 200 -> init_busy stays 1 for a full 450 cycles after release; no wr_ack or rd_ack during that time.
REQ-033 Pixel at v_coord=580 or h_coord=810 -> tile_valid=0 and tile_sel=0 two cycles later.
